// File: rtl/multi_toggle_pkg.sv
// Shared types and default sizing for the multi-channel toggle generator.
package multi_toggle_pkg;

    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

endpackage

// File: rtl/toggle_chan.sv
// Single toggle channel: divide counter with compare, square/pulse output and tick.
module toggle_chan
    import multi_toggle_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic             sq,
    output logic             tk
);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_e            mode_q, mode_d;
    logic             sq_q, sq_d;
    logic             tk_q, tk_d;
    logic             terminal;

    // >= rather than == so a counter already past div still wraps cleanly.
    assign terminal = en && !wr && (cnt_q >= div_q);

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        sq_d   = sq_q;
        tk_d   = 1'b0;
        if (wr) begin
            div_d  = wr_div;
            mode_d = mode_e'(wr_mode);
            cnt_d  = '0;
            if (mode_e'(wr_mode) == MODE_PULSE) begin
                sq_d = 1'b0;
            end
        end else if (terminal) begin
            cnt_d = '0;
            tk_d  = 1'b1;
            sq_d  = (mode_q == MODE_PULSE) ? 1'b1 : ~sq_q;
        end else begin
            if (en) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (mode_q == MODE_PULSE) begin
                sq_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q  <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_TOGGLE;
            sq_q   <= 1'b0;
            tk_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            sq_q   <= sq_d;
            tk_q   <= tk_d;
        end
    end

    assign sq = sq_q;
    assign tk = tk_q;

endmodule

// File: rtl/multi_toggle_gen.sv
// Bank of NUM_CH independent toggle channels sharing one configuration write port.
module multi_toggle_gen
    import multi_toggle_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] sq_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] wr_sel;

    // Out-of-range channel indices match no channel and are dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        toggle_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .en      (ch_en[g]),
            .wr      (wr_sel[g]),
            .wr_div  (cfg_div),
            .wr_mode (cfg_mode),
            .sq      (sq_out[g]),
            .tk      (tick[g])
        );
    end

endmodule

// File: tb/tb_multi_toggle_gen.sv
// Directed plus randomized bench for multi_toggle_gen against an interval-based reference model.
module tb_multi_toggle_gen;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CH_W   = 2;

    logic              clock;
    logic              reset;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] sq_out;
    logic [NUM_CH-1:0] tick;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: enabled cycles still to go before the next terminal, per channel.
    int m_div  [NUM_CH];
    int m_left [NUM_CH];
    bit m_mode [NUM_CH];
    bit m_sq   [NUM_CH];
    bit m_tk   [NUM_CH];

    multi_toggle_gen #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .ch_en    (ch_en),
        .sq_out   (sq_out),
        .tick     (tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                m_div[c] = 0; m_left[c] = 0; m_mode[c] = 0; m_sq[c] = 0; m_tk[c] = 0;
            end else if (cfg_we && (int'(cfg_ch) == c)) begin
                m_div[c]  = int'(cfg_div);
                m_left[c] = int'(cfg_div);
                m_mode[c] = cfg_mode;
                m_tk[c]   = 0;
                if (cfg_mode) m_sq[c] = 0;
            end else if (ch_en[c]) begin
                if (m_left[c] == 0) begin
                    m_left[c] = m_div[c];
                    m_tk[c]   = 1;
                    m_sq[c]   = m_mode[c] ? 1'b1 : !m_sq[c];
                end else begin
                    m_left[c] = m_left[c] - 1;
                    m_tk[c]   = 0;
                    if (m_mode[c]) m_sq[c] = 0;
                end
            end else begin
                m_tk[c] = 0;
                if (m_mode[c]) m_sq[c] = 0;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [NUM_CH-1:0] obs,
                         input logic [NUM_CH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs compared against the model #1 after the edge.
    task automatic step();
        logic [NUM_CH-1:0] e_sq, e_tk;
        model_edge();
        @(posedge clock);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            e_sq[c] = m_sq[c];
            e_tk[c] = m_tk[c];
        end
        check("model_sq", sq_out, e_sq);
        check("model_tick", tick, e_tk);
    endtask

    task automatic wr(input int ch, input int div, input bit mode);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_div  = CNT_W'(div);
        cfg_mode = mode;
        step();
        cfg_we   = 1'b0;
    endtask

    initial begin
        int n_tk, n_hi, waited;
        bit seen;
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0; ch_en = '0;

        // Reset state
        step();
        step();
        check("reset_sq", sq_out, 3'b000);
        check("reset_tick", tick, 3'b000);

        // D=0 everywhere: divide-by-2 square, continuous tick
        reset = 1'b0;
        ch_en = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            check("div0_sq", sq_out, (k % 2 == 0) ? 3'b111 : 3'b000);
            check("div0_tick", tick, 3'b111);
        end

        // ch1 D=3 TOGGLE: 4 ticks and 8 high samples in 16 cycles
        wr(1, 3, 1'b0);
        check("wr_no_tick", tick, 3'b101);
        n_tk = 0; n_hi = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            n_tk += int'(tick[1]);
            n_hi += int'(sq_out[1]);
        end
        check_int("d3_tick_count", n_tk, 4);
        check_int("d3_high_count", n_hi, 8);

        // ch2 D=2 PULSE: coincident one-cycle pulses every 3 cycles
        wr(2, 2, 1'b1);
        check("pulse_wr_sq2", {2'b00, sq_out[2]}, 3'b000);
        n_tk = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            n_tk += int'(tick[2]);
            check("pulse_coincident", {2'b00, sq_out[2]}, {2'b00, tick[2]});
        end
        check_int("pulse_count", n_tk, 3);

        // ch1 D=5: freeze at cnt=2, resume needs 4 more enabled cycles
        wr(1, 5, 1'b0);
        step();
        step();
        ch_en = 3'b101;
        for (int k = 0; k < 7; k++) begin
            step();
            check("frozen_tick1", {2'b00, tick[1]}, 3'b000);
        end
        ch_en = 3'b111;
        waited = 0; seen = 0;
        while (!seen && waited < 12) begin
            step();
            waited++;
            seen = tick[1];
        end
        check_int("resume_latency", seen ? waited : -1, 4);

        // Write lands in ch1's terminal cycle: write wins
        wr(1, 3, 1'b0);
        step(); step(); step();
        wr(1, 3, 1'b0);
        check("wr_wins_tick1", {2'b00, tick[1]}, 3'b000);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("post_wr_tick1", {2'b00, tick[1]}, (k == 4) ? 3'b001 : 3'b000);
        end

        // Out-of-range channel index is ignored
        wr(3, 0, 1'b1);
        step(); step();

        // Reset mid-pattern with D=7
        wr(0, 7, 1'b0);
        wr(1, 7, 1'b0);
        wr(2, 7, 1'b1);
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        step();
        check("midreset_sq", sq_out, 3'b000);
        check("midreset_tick", tick, 3'b000);
        reset = 1'b0;
        step();
        check("postreset_sq", sq_out, 3'b111);
        check("postreset_tick", tick, 3'b111);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            reset    = ($urandom_range(0, 59) == 0);
            ch_en    = NUM_CH'($urandom);
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_ch   = CH_W'($urandom_range(0, 3));
            cfg_div  = CNT_W'($urandom_range(0, 6));
            cfg_mode = 1'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
